vsid_packet_filter: RTL and testbench
=====================================

Name: vsid_packet_filter

Overview:
- Stage directly downstream of the VSID parser in the full NMU ingress path.
- Consumes the parser's AXI-Stream output, whose tuser carries a one-hot destination mask plus five parse-status flags.
- Drops whole packets flagged by configurable masks or with an invalid destination. Converts the one-hot mask to binary tdest for the switch fabric.
- Keeps forwarded and dropped packet counters.

Parameters:
- AXIS_BUS_WIDTH, 64, data width in bits. NUM_BUS_BYTES = AXIS_BUS_WIDTH/8.
- AXIS_ID_WIDTH, 4, binary tdest width. NUM_AXIS_ID = 2**AXIS_ID_WIDTH.
- COUNTER_WIDTH, 32, width of each statistics counter.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- axis_in_tdata  in  AXIS_BUS_WIDTH  packet data.
- axis_in_tuser  in  NUM_AXIS_ID+5  bits [NUM_AXIS_ID-1:0] are the one-hot route; bits [NUM_AXIS_ID+4:NUM_AXIS_ID] are the parse flags. Valid on the first beat only.
- axis_in_tkeep  in  NUM_BUS_BYTES  byte enables.
- axis_in_tlast  in  1  end of packet.
- axis_in_tvalid  in  1  input valid.
- axis_in_tready  out  1  input ready.
- axis_out_tdata  out  AXIS_BUS_WIDTH  forwarded data.
- axis_out_tdest  out  AXIS_ID_WIDTH  binary destination.
- axis_out_tkeep  out  NUM_BUS_BYTES  byte enables.
- axis_out_tlast  out  1  end of packet.
- axis_out_tvalid  out  1  output valid.
- axis_out_tready  in  1  output ready.
- drop_flag_mask  in  5  a set bit drops any packet whose matching parse flag is set.
- counter_clear  in  1  synchronous clear of both counters.
- fwd_pkt_count  out  COUNTER_WIDTH  packets forwarded.
- drop_pkt_count  out  COUNTER_WIDTH  packets dropped.

Behaviour:
- Reset values: axis_out_tvalid=0; axis_out_tdata/tdest/tkeep/tlast=0; counters=0; axis_in_tready=0 while areset is asserted; FSM in HEAD.
- Transfer rule: a beat transfers when tvalid&tready.
- Drop decision (combinational on the first beat): drop = |(flags & drop_flag_mask) OR route==0 OR route not one-hot (popcount>1).
- tdest = index of the set route bit. It is computed only when route is one-hot.
- FSM states:
  - HEAD: awaiting the first beat. On accept, the drop decision is evaluated.
    - Forwarded beat with tlast=1: stay in HEAD.
    - Forwarded beat with tlast=0: go to PASS and latch tdest.
    - Dropped beat with tlast=0: go to DROP.
    - Dropped beat with tlast=1: stay in HEAD; the counter still updates.
  - PASS: beats forwarded with the latched tdest. An accepted tlast returns to HEAD.
  - DROP: axis_in_tready=1 unconditionally. Beats are discarded and no output is produced. An accepted tlast returns to HEAD.
- Output path: a two-entry skid buffer (main + skid registers).
  - Latency: 1 cycle from input accept to axis_out_tvalid.
  - Sustains 1 beat/cycle under continuous tready.
  - axis_in_tready is registered: equals "skid empty" in HEAD/PASS, and is forced to 1 in DROP. No combinational path from axis_out_tready to axis_in_tready.
  - A head beat that resolves to drop is accepted even when the skid is occupied only if tready is high. The decision uses the beat presented, so a stalled head beat is not re-evaluated with different flags (tuser must be held stable while tvalid is high).
- Output stall: tdata/tdest/tkeep/tlast are held stable while axis_out_tvalid=1 and axis_out_tready=0.
- Counters:
  - fwd_pkt_count increments on accept of a forwarded tlast beat; drop_pkt_count increments on accept of a dropped tlast beat.
  - Both saturate at all-ones (no wrap).
  - counter_clear has priority over an increment in the same cycle; the result is 0.
- drop_flag_mask is sampled only at the head beat. Changing it mid-packet does not affect the packet in flight.
- Reset mid-packet: the FSM returns to HEAD and the skid buffer empties. Beats already buffered are lost. The first post-reset beat is treated as a packet head, even if it is upstream's mid-packet data.

Test Plan:
- Single 3-beat packet, route=16'h0020, flags=0, mask=5'h1F, tready=1 → 3 output beats, tdest=5, tvalid 1 cycle after each input, fwd_pkt_count=1.
- Packet with flags=5'b00100, mask=5'b00100 → no output beats, in tready=1 every cycle, drop_pkt_count=1. Same packet with mask=5'b00011 → forwarded.
- Route=16'h0000 and route=16'h0011 (each 2 beats) → both dropped, drop_pkt_count=2; a following valid packet, route=16'h8000, gets tdest=15.
- Back-to-back 1-beat packets, route bits 0..15, with axis_out_tready toggling 1/0 every cycle → all 16 emerged in order with correct tdest, no duplication/loss, data stable during stalls.
- Preload drop_pkt_count to saturation (2^COUNTER_WIDTH-1 drops, or COUNTER_WIDTH=4 build with 16 drops) → stays at all-ones. counter_clear asserted coincident with a drop tlast → 0.
- Assert areset during beat 2 of a 4-beat packet → out tvalid=0 immediately, counters=0; next beat is treated as a head, with its tuser applied.

Source files
------------

// File: rtl/vsid_packet_filter.sv
// vsid_packet_filter: drops flagged or misrouted packets, maps the one-hot route to a binary tdest,
// and counts forwarded/dropped packets behind a registered-ready two-entry skid buffer.
module vsid_packet_filter #(
   parameter  int AXIS_BUS_WIDTH = 64,
   parameter  int AXIS_ID_WIDTH  = 4,
   parameter  int COUNTER_WIDTH  = 32,
   localparam int NUM_BUS_BYTES  = AXIS_BUS_WIDTH/8,
   localparam int NUM_AXIS_ID    = 2**AXIS_ID_WIDTH
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
   input  logic [NUM_AXIS_ID+4:0]    axis_in_tuser,
   input  logic [NUM_BUS_BYTES-1:0]  axis_in_tkeep,
   input  logic                      axis_in_tlast,
   input  logic                      axis_in_tvalid,
   output logic                      axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
   output logic [AXIS_ID_WIDTH-1:0]  axis_out_tdest,
   output logic [NUM_BUS_BYTES-1:0]  axis_out_tkeep,
   output logic                      axis_out_tlast,
   output logic                      axis_out_tvalid,
   input  logic                      axis_out_tready,
   input  logic [4:0]                drop_flag_mask,
   input  logic                      counter_clear,
   output logic [COUNTER_WIDTH-1:0]  fwd_pkt_count,
   output logic [COUNTER_WIDTH-1:0]  drop_pkt_count
);
   localparam int BW = AXIS_BUS_WIDTH + AXIS_ID_WIDTH + NUM_BUS_BYTES + 1;
   typedef enum logic [1:0] {HEAD, PASS, DROP} state_t;
   state_t                   state_q, state_d;
   logic [NUM_AXIS_ID-1:0]   route;
   logic [4:0]               flags;
   logic                     one_hot, drop;
   logic [AXIS_ID_WIDTH-1:0] head_dest, beat_dest, tdest_q, tdest_d;
   logic                     accept, fwd_beat, drop_beat, pop;
   logic [BW-1:0]            in_beat, main_q, main_d, skid_q, skid_d;
   logic                     main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
   logic [COUNTER_WIDTH-1:0] fwd_q, fwd_d, drop_q, drop_d;

   assign route   = axis_in_tuser[NUM_AXIS_ID-1:0];
   assign flags   = axis_in_tuser[NUM_AXIS_ID +: 5];
   assign one_hot = (route != '0) && ((route & (route - NUM_AXIS_ID'(1))) == '0);
   assign drop    = (|(flags & drop_flag_mask)) || !one_hot;

   // only meaningful when the route is one-hot; otherwise the packet is dropped anyway
   always_comb begin
      head_dest = '0;
      for (int i = 0; i < NUM_AXIS_ID; i++)
         if (route[i]) head_dest = head_dest | AXIS_ID_WIDTH'(i);
   end

   always_ff @(posedge aclk or posedge areset)
      if (areset) state_q <= HEAD;
      else        state_q <= state_d;

   always_comb begin
      state_d = !accept            ? state_q :
                axis_in_tlast      ? HEAD    :
                (state_q != HEAD)  ? state_q :
                drop               ? DROP    : PASS;
   end

   always_comb begin
      accept    = axis_in_tvalid && in_ready_q;
      fwd_beat  = accept && (state_q == PASS || (state_q == HEAD && !drop));
      drop_beat = accept && (state_q == DROP || (state_q == HEAD && drop));
      beat_dest = (state_q == HEAD) ? head_dest : tdest_q;
      tdest_d   = fwd_beat ? beat_dest : tdest_q;
   end

   // ready is registered, so the skid entry absorbs the beat accepted while main is stalled
   always_comb begin
      in_beat  = {axis_in_tdata, beat_dest, axis_in_tkeep, axis_in_tlast};
      pop      = main_v_q && axis_out_tready;
      main_d   = main_q;
      main_v_d = main_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (skid_v_q) begin
         if (pop) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
         end
      end else if (fwd_beat) begin
         if (!main_v_q || pop) begin
            main_d   = in_beat;
            main_v_d = 1'b1;
         end else begin
            skid_d   = in_beat;
            skid_v_d = 1'b1;
         end
      end else if (pop) main_v_d = 1'b0;
      in_ready_d = (state_d == DROP) || !skid_v_d;
   end

   always_comb begin
      fwd_d  = counter_clear ? '0 :
               (fwd_beat && axis_in_tlast && !(&fwd_q)) ? fwd_q + COUNTER_WIDTH'(1) : fwd_q;
      drop_d = counter_clear ? '0 :
               (drop_beat && axis_in_tlast && !(&drop_q)) ? drop_q + COUNTER_WIDTH'(1) : drop_q;
   end

   always_ff @(posedge aclk or posedge areset)
      if (areset) begin
         tdest_q    <= '0;
         main_q     <= '0;
         main_v_q   <= 1'b0;
         skid_q     <= '0;
         skid_v_q   <= 1'b0;
         in_ready_q <= 1'b0;
         fwd_q      <= '0;
         drop_q     <= '0;
      end else begin
         tdest_q    <= tdest_d;
         main_q     <= main_d;
         main_v_q   <= main_v_d;
         skid_q     <= skid_d;
         skid_v_q   <= skid_v_d;
         in_ready_q <= in_ready_d;
         fwd_q      <= fwd_d;
         drop_q     <= drop_d;
      end

   assign {axis_out_tdata, axis_out_tdest, axis_out_tkeep, axis_out_tlast} = main_q;
   assign axis_out_tvalid = main_v_q;
   assign axis_in_tready  = in_ready_q;
   assign fwd_pkt_count   = fwd_q;
   assign drop_pkt_count  = drop_q;
endmodule

// File: tb/tb_vsid_packet_filter.sv
// tb_vsid_packet_filter: directed bench for vsid_packet_filter, built with 4-bit counters
// so saturation is reachable in a handful of packets.
module tb_vsid_packet_filter;
   localparam int CW = 4;
   logic          aclk = 1'b0, areset = 1'b1;
   logic [63:0]   in_data;
   logic [20:0]   in_user;
   logic [7:0]    in_keep;
   logic          in_last, in_valid, in_ready;
   logic [63:0]   out_data;
   logic [3:0]    out_dest;
   logic [7:0]    out_keep;
   logic          out_last, out_valid, out_ready;
   logic [4:0]    mask;
   logic          clr;
   logic [CW-1:0] fwd_cnt, drop_cnt;
   int            n_chk = 0, n_fail = 0, w;
   logic          done;
   logic [76:0]   got[$], exp_q[$];
   logic          stall_q = 1'b0;
   logic [76:0]   stall_v;

   vsid_packet_filter #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .COUNTER_WIDTH(CW)) dut (
      .aclk(aclk), .areset(areset),
      .axis_in_tdata(in_data), .axis_in_tuser(in_user), .axis_in_tkeep(in_keep),
      .axis_in_tlast(in_last), .axis_in_tvalid(in_valid), .axis_in_tready(in_ready),
      .axis_out_tdata(out_data), .axis_out_tdest(out_dest), .axis_out_tkeep(out_keep),
      .axis_out_tlast(out_last), .axis_out_tvalid(out_valid), .axis_out_tready(out_ready),
      .drop_flag_mask(mask), .counter_clear(clr),
      .fwd_pkt_count(fwd_cnt), .drop_pkt_count(drop_cnt)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // output monitor: records every transferred beat and checks hold-stability across stalls
   always @(posedge aclk or posedge areset) begin
      if (areset) stall_q = 1'b0;
      else begin
         if (stall_q) chk("stall_hold", 128'({out_data, out_dest, out_keep, out_last}), 128'(stall_v));
         if (out_valid && out_ready) got.push_back({out_data, out_dest, out_keep, out_last});
         stall_q = out_valid && !out_ready;
         stall_v = {out_data, out_dest, out_keep, out_last};
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [63:0] d, input logic [15:0] route, input logic [4:0] flags,
                       input logic last, output int waited);
      in_data  = d;
      in_user  = {flags, route};
      in_keep  = last ? 8'h0F : 8'hFF;
      in_last  = last;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 50) begin
         @(posedge aclk);
         #1;
         waited++;
      end
      chk("accept_wait", 128'(waited < 50), 128'(1));
      @(posedge aclk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_beat(input logic [63:0] d, input logic [3:0] dest, input logic last);
      exp_q.push_back({d, dest, last ? 8'h0F : 8'hFF, last});
   endtask

   task automatic check_out(input string tag);
      chk({tag, "_count"}, 128'(got.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, 128'(got[i]), 128'(exp_q[i]));
      got.delete();
      exp_q.delete();
   endtask

   task automatic pulse_clear();
      clr = 1'b1;
      idle(1);
      clr = 1'b0;
   endtask

   initial begin
      in_valid = 0; in_data = '0; in_user = '0; in_keep = '0; in_last = 0;
      out_ready = 1; mask = 5'h1F; clr = 0; done = 0;
      idle(2);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_beat", 128'({out_data, out_dest, out_keep, out_last}), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_counts", 128'({fwd_cnt, drop_cnt}), 128'(0));
      areset = 0;
      idle(1);
      chk("post_rst_ready", 128'(in_ready), 128'(1));
      // 3-beat forwarded packet, route bit 5
      for (int i = 0; i < 3; i++) begin
         send(64'h1000 + 64'(i), 16'h0020, 5'h00, i == 2, w);
         chk("t1_lat_valid", 128'(out_valid), 128'(1));
         chk("t1_lat_data", 128'(out_data), 128'(64'h1000 + 64'(i)));
         expect_beat(64'h1000 + 64'(i), 4'd5, i == 2);
      end
      idle(2);
      check_out("t1_out");
      chk("t1_fwd", 128'(fwd_cnt), 128'(1));
      // flag-masked drop, then the same packet with a non-matching mask
      mask = 5'b00100;
      for (int i = 0; i < 3; i++) begin
         send(64'h2000 + 64'(i), 16'h0020, 5'b00100, i == 2, w);
         chk("t2_drop_ready", 128'(w), 128'(0));
         chk("t2_no_valid", 128'(out_valid), 128'(0));
      end
      idle(2);
      check_out("t2_drop_out");
      chk("t2_drop_cnt", 128'(drop_cnt), 128'(1));
      mask = 5'b00011;
      for (int i = 0; i < 3; i++) begin
         send(64'h2100 + 64'(i), 16'h0020, 5'b00100, i == 2, w);
         expect_beat(64'h2100 + 64'(i), 4'd5, i == 2);
      end
      idle(2);
      check_out("t2_fwd_out");
      chk("t2_fwd_cnt", 128'(fwd_cnt), 128'(2));
      // invalid routes: zero and multi-hot, then route bit 15
      pulse_clear();
      chk("t3_clear", 128'({fwd_cnt, drop_cnt}), 128'(0));
      mask = 5'h1F;
      send(64'h3000, 16'h0000, 5'h00, 1'b0, w);
      send(64'h3001, 16'h0000, 5'h00, 1'b1, w);
      send(64'h3100, 16'h0011, 5'h00, 1'b0, w);
      send(64'h3101, 16'h0011, 5'h00, 1'b1, w);
      send(64'h3200, 16'h8000, 5'h00, 1'b0, w);
      send(64'h3201, 16'h8000, 5'h00, 1'b1, w);
      expect_beat(64'h3200, 4'd15, 1'b0);
      expect_beat(64'h3201, 4'd15, 1'b1);
      idle(2);
      check_out("t3_out");
      chk("t3_drop_cnt", 128'(drop_cnt), 128'(2));
      chk("t3_fwd_cnt", 128'(fwd_cnt), 128'(1));
      // 16 back-to-back single-beat packets under a toggling output ready
      pulse_clear();
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               send(64'hA000 + 64'(i), 16'h1 << i, 5'h00, 1'b1, w);
               expect_beat(64'hA000 + 64'(i), 4'(i), 1'b1);
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge aclk);
               #1;
               out_ready = ~out_ready;
            end
         end
      join
      out_ready = 1;
      idle(4);
      check_out("t4_out");
      chk("t4_fwd_sat", 128'(fwd_cnt), 128'(15));
      // drop counter saturation, then clear coincident with a dropped tlast
      pulse_clear();
      for (int i = 0; i < 16; i++) send(64'h5000 + 64'(i), 16'h0000, 5'h00, 1'b1, w);
      chk("t5_drop_sat", 128'(drop_cnt), 128'(15));
      chk("t5_fwd_zero", 128'(fwd_cnt), 128'(0));
      clr = 1'b1;
      send(64'h5100, 16'h0000, 5'h00, 1'b1, w);
      clr = 1'b0;
      chk("t5_clear_prio", 128'(drop_cnt), 128'(0));
      // reset in the middle of a stalled 4-beat packet
      send(64'h6000, 16'h0002, 5'h00, 1'b1, w);
      send(64'h6001, 16'h0000, 5'h00, 1'b1, w);
      expect_beat(64'h6000, 4'd1, 1'b1);
      idle(2);
      check_out("t6_pre_out");
      chk("t6_pre_cnts", 128'({fwd_cnt, drop_cnt}), 128'({4'd1, 4'd1}));
      out_ready = 0;
      send(64'h6100, 16'h0004, 5'h00, 1'b0, w);
      send(64'h6101, 16'h0004, 5'h00, 1'b0, w);
      chk("t6_skid_full", 128'(in_ready), 128'(0));
      in_data = 64'h6102; in_user = {5'h00, 16'h0004}; in_keep = 8'hFF; in_last = 0; in_valid = 1;
      #2;
      areset = 1;
      #1;
      chk("t6_rst_valid", 128'(out_valid), 128'(0));
      chk("t6_rst_cnts", 128'({fwd_cnt, drop_cnt}), 128'(0));
      chk("t6_rst_ready", 128'(in_ready), 128'(0));
      idle(1);
      areset = 0;
      in_valid = 0;
      out_ready = 1;
      send(64'h6200, 16'h0200, 5'h00, 1'b1, w);
      expect_beat(64'h6200, 4'd9, 1'b1);
      idle(2);
      check_out("t6_post_out");
      chk("t6_post_fwd", 128'(fwd_cnt), 128'(1));
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
